my9262_frame_sched: RTL and testbench
=====================================

// Module: my9262_frame_sched
// PURPOSE
//  Frame scheduler for the my9262 serial LED-driver datapath. Holds a frame of 16-bit
//  grey-scale words written over Avalon-MM and streams them word by word into the
//  my9262 shift engine via a start/busy handshake. Requests a latch after the last word,
//  then waits a programmable refresh gap before the next frame.
//  Sits between the Avalon slave interface and the my9262 serial engine, in place of a
//  bare data/start register pair.
// PARAMETERS
//  CHIPS     4    daisy-chained my9262 devices; frame length N = CHIPS*16 words
//  GAP_W     16   width of refresh-gap counter (csi_clk cycles)
// PORTS
//  csi_clk        in   1     system clock, all logic rising-edge
//  rsi_reset_n    in   1     asynchronous active-low reset
//  avs_address    in   2     0=CTRL 1=WPTR 2=WDATA 3=GAP
//  avs_write      in   1     Avalon write strobe, zero wait states
//  avs_writedata  in   32    Avalon write data
//  drv_data       out  16    word presented to shift engine
//  drv_start      out  1     one-cycle pulse: drv_data valid, begin shift
//  drv_busy       in   1     shift engine busy
//  drv_latch      out  1     one-cycle latch request after the last word of a frame
//  frame_irq      out  1     sticky frame-complete flag, cleared by a CTRL write with bit2=1
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; CTRL=0; WPTR=0; GAP=0; buffer contents undefined.
//  Registers:
//   - CTRL: bit0 EN (run continuously), bit1 ONE (run one frame, self-clears),
//     bit2 IRQ_CLR (write-1 pulse).
//   - WPTR: buffer write index, masked to clog2(N) bits.
//   - WDATA: stores avs_writedata[15:0] at buffer[WPTR], then WPTR+1 (wraps N-1 -> 0).
//   - GAP: idle cycles between drv_latch and the next frame.
//  Buffer: N x 16 synchronous RAM, 1 write port (Avalon) + 1 read port (FSM), 1-cycle read.
//  FSM states:
//   - IDLE:  if EN|ONE -> LOAD with rd_idx=0; clear ONE on entry to LOAD.
//   - LOAD:  issue read of buffer[rd_idx]; -> SEND next cycle.
//   - SEND:  drv_data <= read word, drv_start=1 for exactly 1 cycle -> ACK.
//   - ACK:   wait for drv_busy=1 (at most 3 cycles; if not seen, treat the word as sent)
//            -> WAIT.
//   - WAIT:  wait for drv_busy=0; if rd_idx==N-1 -> LATCH, else rd_idx+1 -> LOAD.
//   - LATCH: drv_latch=1 for 1 cycle; frame_irq<=1; gap_cnt<=GAP -> GAP.
//   - GAP:   decrement to 0 (GAP=0: stay 1 cycle); then EN ? LOAD (rd_idx=0) : IDLE.
//  Word order: buffer[0] is shifted first (farthest chip, ch15 first); the engine
//  drives MSB first.
//  drv_data holds its value from SEND until the next SEND.
//  Clearing EN mid-frame: the current frame completes, including latch and gap, then -> IDLE.
//  Frames are never truncated.
//  Simultaneous WDATA write and FSM read of the same index: the read returns the old word.
//  Write tearing within a frame is allowed; software writes during GAP.
//  Simultaneous LATCH set and IRQ_CLR on frame_irq: the set wins.
//  Asynchronous reset mid-shift: outputs drop to 0 immediately; next frame restarts at
//  rd_idx=0.
//  Throughput: per word = 3 cycles + engine busy time + handshake.
// TESTING
//  1. Reset: assert rsi_reset_n=0 mid-SEND -> drv_start=drv_latch=frame_irq=0, drv_data=0
//     asynchronously.
//  2. CHIPS=1: WPTR=0, write 16 words 0x1000..0x100F, CTRL=ONE -> 16 drv_start pulses in
//     order 0x1000..0x100F; model busy 20 cycles each; 1 drv_latch after the last busy
//     fall; frame_irq=1; FSM returns to IDLE.
//  3. EN=1, GAP=100 -> latch-to-first-start spacing is exactly 100+2 cycles; frames repeat.
//     Clear EN mid-frame -> exactly one more latch, then no starts.
//  4. Busy never asserts -> each word advances after the 3-cycle ACK timeout; 16 starts
//     and 1 latch.
//  5. WPTR wrap: WPTR=15, write 0xAAAA,0xBBBB -> buffer[15]=0xAAAA, buffer[0]=0xBBBB.
//  6. IRQ_CLR written in the same cycle as LATCH -> frame_irq stays 1; a later IRQ_CLR
//     clears it.

Source files
------------

// File: rtl/my9262_frame_sched.sv
// Frame scheduler for the my9262 LED-driver chain: an Avalon-written frame buffer
// streamed word by word into the shift engine, then a latch and a refresh gap.
module my9262_frame_sched #(
  parameter int CHIPS = 4,
  parameter int GAP_W = 16
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [15:0] drv_data,
  output logic        drv_start,
  input  logic        drv_busy,
  output logic        drv_latch,
  output logic        frame_irq
);
  localparam int N  = CHIPS * 16;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_LATCH = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  logic [2:0]       state;
  logic             ctrl_en, ctrl_one;
  logic [AW-1:0]    wptr, rd_idx;
  logic [GAP_W-1:0] gap_reg, gap_cnt;
  logic [1:0]       ack_cnt;
  logic [15:0]      mem [N];
  logic             wr_ctrl, wr_wptr, wr_wdata, wr_gap;

  assign wr_ctrl   = avs_write && (avs_address == 2'd0);
  assign wr_wptr   = avs_write && (avs_address == 2'd1);
  assign wr_wdata  = avs_write && (avs_address == 2'd2);
  assign wr_gap    = avs_write && (avs_address == 2'd3);
  assign drv_start = (state == S_SEND);
  assign drv_latch = (state == S_LATCH);

  always_ff @(posedge csi_clk)
    if (wr_wdata) mem[wptr] <= avs_writedata[15:0];

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      ctrl_en  <= 1'b0;
      ctrl_one <= 1'b0;
      wptr     <= '0;
      gap_reg  <= '0;
    end else begin
      if (state == S_IDLE && (ctrl_en || ctrl_one)) ctrl_one <= 1'b0;
      // a software CTRL write in the same cycle overrides the self-clear
      if (wr_ctrl) begin
        ctrl_en  <= avs_writedata[0];
        ctrl_one <= avs_writedata[1];
      end
      if (wr_wptr)       wptr <= avs_writedata[AW-1:0];
      else if (wr_wdata) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (wr_gap) gap_reg <= avs_writedata[GAP_W-1:0];
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state     <= S_IDLE;
      rd_idx    <= '0;
      gap_cnt   <= '0;
      ack_cnt   <= '0;
      drv_data  <= '0;
      frame_irq <= 1'b0;
    end else begin
      if (state == S_LATCH)                     frame_irq <= 1'b1;
      else if (wr_ctrl && avs_writedata[2])     frame_irq <= 1'b0;
      case (state)
        S_IDLE: begin
          rd_idx <= '0;
          if (ctrl_en || ctrl_one) state <= S_LOAD;
        end
        // the read register doubles as drv_data, so it holds until the next LOAD
        S_LOAD: begin
          drv_data <= mem[rd_idx];
          state    <= S_SEND;
        end
        S_SEND: begin
          ack_cnt <= '0;
          state   <= S_ACK;
        end
        S_ACK:
          if (drv_busy || ack_cnt == 2'd2) state <= S_WAIT;
          else                             ack_cnt <= ack_cnt + 1'b1;
        S_WAIT:
          if (!drv_busy) begin
            if (rd_idx == LAST) state <= S_LATCH;
            else begin
              rd_idx <= rd_idx + 1'b1;
              state  <= S_LOAD;
            end
          end
        S_LATCH: begin
          gap_cnt <= gap_reg;
          rd_idx  <= '0;
          state   <= S_GAP;
        end
        // GAP lasts max(GAP,1) cycles, so latch-to-start is GAP+2
        S_GAP:
          if (gap_cnt <= GAP_W'(1)) state <= ctrl_en ? S_LOAD : S_IDLE;
          else                      gap_cnt <= gap_cnt - 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_my9262_frame_sched.sv
// Randomized bench for my9262_frame_sched: transaction scoreboard over the frame
// buffer, IRQ model, engine busy model and latch-to-start spacing.
module tb_my9262_frame_sched;
  localparam int N = 16;

  logic        csi_clk = 1'b0;
  logic        rsi_reset_n = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [15:0] drv_data;
  logic        drv_start;
  logic        drv_busy = 1'b0;
  logic        drv_latch;
  logic        frame_irq;

  my9262_frame_sched #(.CHIPS(1), .GAP_W(16)) dut (
    .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n), .avs_address(avs_address),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .drv_data(drv_data),
    .drv_start(drv_start), .drv_busy(drv_busy), .drv_latch(drv_latch),
    .frame_irq(frame_irq)
  );

  always #5 csi_clk = ~csi_clk;

  int checks = 0, failures = 0;
  logic [15:0] model_mem [N];
  int model_wptr = 0;
  bit model_irq = 0;
  int widx = 0, starts = 0, latches = 0, cyc = 0, last_latch_cyc = -1;
  logic [15:0] last_data = '0;
  logic [15:0] captured [$];
  bit spacing_en = 0;
  int exp_space = 0;
  int blen_mode = 20, bdly_max = 0;
  int b_dly = 0, b_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Register/IRQ model: the buffer as a plain array, the flag as set-wins-over-clear
  always @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      model_irq  = 0;
      model_wptr = 0;
    end else begin
      if (drv_latch) model_irq = 1;
      else if (avs_write && avs_address == 2'd0 && avs_writedata[2]) model_irq = 0;
      if (avs_write && avs_address == 2'd1) model_wptr = int'(avs_writedata[3:0]);
      if (avs_write && avs_address == 2'd2) begin
        model_mem[model_wptr] = avs_writedata[15:0];
        model_wptr = (model_wptr + 1) % N;
      end
    end
  end

  // Shift-engine model: optional busy delay, then busy for a chosen length
  always @(negedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      b_dly = 0; b_len = 0; drv_busy = 1'b0;
    end else begin
      if (drv_start) begin
        chk("start_while_engine_busy", {31'd0, (b_dly != 0 || b_len != 0)}, 32'd0);
        b_len = (blen_mode < 0) ? int'($urandom_range(1, 25)) : blen_mode;
        b_dly = (b_len == 0) ? 0 : int'($urandom_range(0, bdly_max));
      end else if (b_dly > 0) b_dly--;
      else if (b_len > 0) b_len--;
      drv_busy = (b_dly == 0 && b_len > 0);
    end
  end

  // Compare process
  always @(negedge csi_clk) begin
    if (!rsi_reset_n) begin
      widx = 0; last_data = '0; last_latch_cyc = -1;
    end else begin
      cyc++;
      if (drv_start) begin
        chk("word_index_in_frame", {31'd0, widx < N}, 32'd1);
        if (widx < N) chk("start_data", {16'd0, drv_data}, {16'd0, model_mem[widx]});
        if (spacing_en && widx == 0 && last_latch_cyc >= 0)
          chk("latch_to_start", cyc - last_latch_cyc, exp_space);
        captured.push_back(drv_data);
        last_data = drv_data;
        widx++;
        starts++;
      end else begin
        chk("data_hold", {16'd0, drv_data}, {16'd0, last_data});
      end
      if (drv_latch) begin
        chk("latch_after_last_word", widx, N);
        widx = 0;
        latches++;
        last_latch_cyc = cyc;
      end
      chk("frame_irq", {31'd0, frame_irq}, {31'd0, model_irq});
    end
  end

  task automatic av_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge csi_clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge csi_clk);
    avs_write = 1'b0;
  endtask

  task automatic wait_latches(input int target, input int budget, input string name);
    int n = 0;
    while (latches < target && n < budget) begin @(negedge csi_clk); n++; end
    chk(name, {31'd0, latches >= target}, 32'd1);
  endtask

  // Wait for the LATCH cycle, then write CTRL during it
  task automatic ctrl_at_latch(input logic [31:0] d, input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 3000) begin
      @(negedge csi_clk); n++;
      seen = drv_latch;
    end
    chk(name, {31'd0, seen}, 32'd1);
    avs_address = 2'd0; avs_writedata = d; avs_write = 1'b1;
    @(negedge csi_clk);
    avs_write = 1'b0;
  endtask

  initial begin
    int l0, s0, g, n;
    repeat (3) @(negedge csi_clk);
    chk("reset_start", {31'd0, drv_start}, 32'd0);
    chk("reset_latch", {31'd0, drv_latch}, 32'd0);
    chk("reset_irq", {31'd0, frame_irq}, 32'd0);
    chk("reset_data", {16'd0, drv_data}, 32'd0);
    rsi_reset_n = 1'b1;

    // One frame, fixed 20-cycle busy
    blen_mode = 20; bdly_max = 0;
    av_wr(2'd1, 32'd0);
    for (int i = 0; i < N; i++) av_wr(2'd2, 32'h1000 + i);
    captured.delete();
    av_wr(2'd0, 32'd2);
    wait_latches(1, 3000, "one_frame_latch");
    repeat (100) @(negedge csi_clk);
    chk("one_frame_starts", captured.size(), 16);
    for (int i = 0; i < 16 && i < captured.size(); i++)
      chk("one_frame_word", {16'd0, captured[i]}, 32'h1000 + i);
    chk("one_frame_latches", latches, 1);
    chk("one_frame_irq", {31'd0, frame_irq}, 32'd1);

    // IRQ_CLR coinciding with LATCH: set wins
    av_wr(2'd0, 32'd4);
    repeat (2) @(negedge csi_clk);
    chk("irq_cleared", {31'd0, frame_irq}, 32'd0);
    av_wr(2'd0, 32'd2);
    ctrl_at_latch(32'd4, "irq_race_latch_seen");
    repeat (3) @(negedge csi_clk);
    chk("irq_set_wins", {31'd0, frame_irq}, 32'd1);
    av_wr(2'd0, 32'd4);
    repeat (2) @(negedge csi_clk);
    chk("irq_late_clear", {31'd0, frame_irq}, 32'd0);

    // Busy never asserts: ACK timeout path
    blen_mode = 0;
    captured.delete(); l0 = latches;
    av_wr(2'd0, 32'd2);
    wait_latches(l0 + 1, 2000, "timeout_latch");
    repeat (50) @(negedge csi_clk);
    chk("timeout_starts", captured.size(), 16);
    chk("timeout_latches", latches, l0 + 1);

    // WPTR wrap
    av_wr(2'd1, 32'd15);
    av_wr(2'd2, 32'hAAAA);
    av_wr(2'd2, 32'hBBBB);
    captured.delete(); l0 = latches;
    av_wr(2'd0, 32'd2);
    wait_latches(l0 + 1, 2000, "wrap_latch");
    chk("wrap_count", captured.size(), 16);
    if (captured.size() == 16) begin
      chk("wrap_word0", {16'd0, captured[0]}, 32'hBBBB);
      chk("wrap_word15", {16'd0, captured[15]}, 32'hAAAA);
    end

    // Continuous mode, GAP=100, random data and busy; then clear EN mid-frame
    blen_mode = -1; bdly_max = 2;
    av_wr(2'd1, 32'd0);
    for (int i = 0; i < N; i++) av_wr(2'd2, $urandom);
    av_wr(2'd3, 32'd100);
    exp_space = 102; last_latch_cyc = -1; spacing_en = 1;
    l0 = latches;
    av_wr(2'd0, 32'd1);
    wait_latches(l0 + 3, 8000, "en_three_frames");
    n = 0;
    while (!(widx >= 5 && widx < 12) && n < 3000) begin @(negedge csi_clk); n++; end
    av_wr(2'd0, 32'd0);
    l0 = latches;
    wait_latches(l0 + 1, 3000, "en_clear_final_latch");
    s0 = starts;
    repeat (300) @(negedge csi_clk);
    chk("en_clear_one_latch", latches, l0 + 1);
    chk("en_clear_no_starts", starts, s0);

    // Random small gaps (including 0) in continuous mode
    for (int k = 0; k < 4; k++) begin
      g = (k == 0) ? 0 : int'($urandom_range(1, 7));
      av_wr(2'd1, 32'd0);
      for (int i = 0; i < N; i++) av_wr(2'd2, $urandom);
      av_wr(2'd3, g);
      exp_space = ((g == 0) ? 1 : g) + 2;
      last_latch_cyc = -1;
      l0 = latches;
      av_wr(2'd0, 32'd1);
      wait_latches(l0 + 1, 3000, "rand_gap_frame");
      ctrl_at_latch(32'd0, "rand_gap_stop");
      repeat (30) @(negedge csi_clk);
      chk("rand_gap_latches", latches, l0 + 2);
    end
    spacing_en = 0;

    // Asynchronous reset mid-SEND, then a fresh frame restarts at word 0
    blen_mode = 20; bdly_max = 0;
    av_wr(2'd1, 32'd0);
    for (int i = 0; i < N; i++) av_wr(2'd2, 32'h5A00 + i + 1);
    l0 = latches;
    av_wr(2'd0, 32'd1);
    wait_latches(l0 + 1, 3000, "pre_reset_frame");
    n = 0; s0 = 0;
    while (s0 < 4 && n < 3000) begin
      @(negedge csi_clk); n++;
      if (drv_start) s0++;
    end
    chk("pre_reset_in_send", {31'd0, drv_start}, 32'd1);
    #1 rsi_reset_n = 1'b0;
    #1;
    chk("async_reset_start", {31'd0, drv_start}, 32'd0);
    chk("async_reset_latch", {31'd0, drv_latch}, 32'd0);
    chk("async_reset_irq", {31'd0, frame_irq}, 32'd0);
    chk("async_reset_data", {16'd0, drv_data}, 32'd0);
    repeat (3) @(negedge csi_clk);
    rsi_reset_n = 1'b1;
    av_wr(2'd1, 32'd0);
    for (int i = 0; i < N; i++) av_wr(2'd2, 32'h5A00 + i);
    captured.delete(); l0 = latches;
    av_wr(2'd0, 32'd2);
    wait_latches(l0 + 1, 3000, "post_reset_frame");
    chk("post_reset_count", captured.size(), 16);
    if (captured.size() > 0) chk("post_reset_first", {16'd0, captured[0]}, 32'h5A00);

    repeat (5) @(negedge csi_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
